// File: rtl/dpram_access_ctrl_if.sv
// Client request/response and RAM port signals for dpram_access_ctrl.
// slave: the controller; master: the client logic plus the RAM that surround it.
interface dpram_access_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              c0_req_valid;
  logic              c0_req_ready;
  logic              c0_req_we;
  logic [ADDR_W-1:0] c0_req_addr;
  logic [DATA_W-1:0] c0_req_wdata;
  logic              c0_rsp_valid;
  logic [DATA_W-1:0] c0_rsp_rdata;

  logic              c1_req_valid;
  logic              c1_req_ready;
  logic              c1_req_we;
  logic [ADDR_W-1:0] c1_req_addr;
  logic [DATA_W-1:0] c1_req_wdata;
  logic              c1_rsp_valid;
  logic [DATA_W-1:0] c1_rsp_rdata;

  logic [ADDR_W-1:0] ram_addr_a;
  logic              ram_read_a;
  logic              ram_write_a;
  logic [DATA_W-1:0] ram_wdata_a;
  logic [DATA_W-1:0] ram_rdata_a;
  logic [ADDR_W-1:0] ram_addr_b;
  logic              ram_read_b;
  logic              ram_write_b;
  logic [DATA_W-1:0] ram_wdata_b;
  logic [DATA_W-1:0] ram_rdata_b;

  modport slave (
    input  c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata,
    output c0_req_ready, c0_rsp_valid, c0_rsp_rdata,
    input  c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata,
    output c1_req_ready, c1_rsp_valid, c1_rsp_rdata,
    output ram_addr_a, ram_read_a, ram_write_a, ram_wdata_a,
    output ram_addr_b, ram_read_b, ram_write_b, ram_wdata_b,
    input  ram_rdata_a, ram_rdata_b
  );

  modport master (
    output c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata,
    input  c0_req_ready, c0_rsp_valid, c0_rsp_rdata,
    output c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata,
    input  c1_req_ready, c1_rsp_valid, c1_rsp_rdata,
    input  ram_addr_a, ram_read_a, ram_write_a, ram_wdata_a,
    input  ram_addr_b, ram_read_b, ram_write_b, ram_wdata_b,
    output ram_rdata_a, ram_rdata_b
  );
endinterface

// File: rtl/dpram_access_ctrl.sv
// Schedules two valid/ready clients onto the A/B ports of a dual-port RAM without collisions.
// Macro DPRAM_CTRL_RR_EN: round-robin conflict priority; undefined: client 0 always wins conflicts.
module dpram_access_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  dpram_access_ctrl_if.slave bus
);

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic vld;
    logic cid;
  } tag_t;

  logic conflict;
  logic win1;
  logic rdy0, rdy1;
  logic acc0, acc1;
  logic a_is_c1;
  cmd_t req0, req1;
  cmd_t cmd_a_d, cmd_a_q, cmd_b_d, cmd_b_q;
  tag_t tag_a1_d, tag_a1_q, tag_a2_q;
  tag_t tag_b1_d, tag_b1_q, tag_b2_q;
  logic rsp0_from_a, rsp0_from_b, rsp1_from_a, rsp1_from_b;
  logic              rsp0_valid_d, rsp0_valid_q, rsp1_valid_d, rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_rdata_d, rsp0_rdata_q, rsp1_rdata_d, rsp1_rdata_q;

  assign conflict = bus.c0_req_valid & bus.c1_req_valid &
                    (bus.c0_req_addr == bus.c1_req_addr) &
                    (bus.c0_req_we | bus.c1_req_we);

`ifdef DPRAM_CTRL_RR_EN
  logic prio_q, prio_d;

  // The winner is always ready, so every conflict resolves in the cycle it is seen.
  assign prio_d = conflict ? ~prio_q : prio_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

  assign win1 = prio_q;
`else
  assign win1 = 1'b0;
`endif

  assign rdy0 = reset & (~conflict | ~win1);
  assign rdy1 = reset & (~conflict | win1);
  assign acc0 = bus.c0_req_valid & rdy0;
  assign acc1 = bus.c1_req_valid & rdy1;

  // Port A carries the priority client when both go out, else whichever one was accepted.
  assign a_is_c1 = acc1 & (~acc0 | win1);

  always_comb begin
    req0       = '0;
    req0.rd    = ~bus.c0_req_we;
    req0.wr    = bus.c0_req_we;
    req0.addr  = bus.c0_req_addr;
    req0.wdata = bus.c0_req_we ? bus.c0_req_wdata : '0;
    req1       = '0;
    req1.rd    = ~bus.c1_req_we;
    req1.wr    = bus.c1_req_we;
    req1.addr  = bus.c1_req_addr;
    req1.wdata = bus.c1_req_we ? bus.c1_req_wdata : '0;
  end

  always_comb begin
    cmd_a_d = '0;
    cmd_b_d = '0;
    if (acc0 | acc1) cmd_a_d = a_is_c1 ? req1 : req0;
    if (acc0 & acc1) cmd_b_d = a_is_c1 ? req0 : req1;
    tag_a1_d.vld = cmd_a_d.rd;
    tag_a1_d.cid = a_is_c1;
    tag_b1_d.vld = cmd_b_d.rd;
    tag_b1_d.cid = ~a_is_c1;
  end

  assign rsp0_from_a = tag_a2_q.vld & ~tag_a2_q.cid;
  assign rsp0_from_b = tag_b2_q.vld & ~tag_b2_q.cid;
  assign rsp1_from_a = tag_a2_q.vld &  tag_a2_q.cid;
  assign rsp1_from_b = tag_b2_q.vld &  tag_b2_q.cid;

  always_comb begin
    rsp0_valid_d = rsp0_from_a | rsp0_from_b;
    rsp1_valid_d = rsp1_from_a | rsp1_from_b;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (rsp0_from_a)      rsp0_rdata_d = bus.ram_rdata_a;
    else if (rsp0_from_b) rsp0_rdata_d = bus.ram_rdata_b;
    if (rsp1_from_a)      rsp1_rdata_d = bus.ram_rdata_a;
    else if (rsp1_from_b) rsp1_rdata_d = bus.ram_rdata_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_a_q      <= '0;
      cmd_b_q      <= '0;
      tag_a1_q     <= '0;
      tag_a2_q     <= '0;
      tag_b1_q     <= '0;
      tag_b2_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      cmd_a_q      <= cmd_a_d;
      cmd_b_q      <= cmd_b_d;
      tag_a1_q     <= tag_a1_d;
      tag_a2_q     <= tag_a1_q;
      tag_b1_q     <= tag_b1_d;
      tag_b2_q     <= tag_b1_q;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign bus.c0_req_ready = rdy0;
  assign bus.c1_req_ready = rdy1;
  assign bus.c0_rsp_valid = rsp0_valid_q;
  assign bus.c0_rsp_rdata = rsp0_rdata_q;
  assign bus.c1_rsp_valid = rsp1_valid_q;
  assign bus.c1_rsp_rdata = rsp1_rdata_q;

  assign bus.ram_addr_a  = cmd_a_q.addr;
  assign bus.ram_read_a  = cmd_a_q.rd;
  assign bus.ram_write_a = cmd_a_q.wr;
  assign bus.ram_wdata_a = cmd_a_q.wdata;
  assign bus.ram_addr_b  = cmd_b_q.addr;
  assign bus.ram_read_b  = cmd_b_q.rd;
  assign bus.ram_write_b = cmd_b_q.wr;
  assign bus.ram_wdata_b = cmd_b_q.wdata;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Testbench for dpram_access_ctrl: RAM model, transaction-level reference monitor,
// a vector table for the ready decision, directed corner sequences and random traffic.
module tb_dpram_access_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dpram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dpram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 16x8 dual-port RAM with registered read data
  logic [7:0] ram_mem [16];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 8'(i * 7 + 3);
      ram_loaded <= 1'b1;
    end else begin
      if (bus.ram_write_a) ram_mem[bus.ram_addr_a] <= bus.ram_wdata_a;
      if (bus.ram_write_b) ram_mem[bus.ram_addr_b] <= bus.ram_wdata_b;
      if (bus.ram_read_a)  bus.ram_rdata_a <= ram_mem[bus.ram_addr_a];
      if (bus.ram_read_b)  bus.ram_rdata_b <= ram_mem[bus.ram_addr_b];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory image updated in acceptance order, expected reads queued per client
  typedef struct {
    int         due;
    logic [7:0] data;
  } rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];
  rsp_t m_ent;
  logic [7:0] shadow [16];
  bit model_init = 1'b0;
  bit prio_m = 1'b0;
  bit m_cf, m_er0, m_er1, m_ea0, m_ea1, m_ev0, m_ev1;

  always @(negedge clk) begin
    if (!model_init) begin
      for (int i = 0; i < 16; i++) shadow[i] = 8'(i * 7 + 3);
      model_init = 1'b1;
    end
    if (!reset) begin
      q0.delete();
      q1.delete();
      prio_m = 1'b0;
    end else begin
      m_ev0 = (q0.size() > 0) && (q0[0].due == cyc);
      m_ev1 = (q1.size() > 0) && (q1[0].due == cyc);
      chk("mon_c0_rsp_valid", bus.c0_rsp_valid, m_ev0);
      chk("mon_c1_rsp_valid", bus.c1_rsp_valid, m_ev1);
      if (m_ev0) begin
        chk("mon_c0_rsp_rdata", bus.c0_rsp_rdata, q0[0].data);
        void'(q0.pop_front());
      end
      if (m_ev1) begin
        chk("mon_c1_rsp_rdata", bus.c1_rsp_rdata, q1[0].data);
        void'(q1.pop_front());
      end
      while (q0.size() > 0 && q0[0].due < cyc) void'(q0.pop_front());
      while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());

      chk("mon_port_a_rw", bus.ram_read_a & bus.ram_write_a, 0);
      chk("mon_port_b_rw", bus.ram_read_b & bus.ram_write_b, 0);
      chk("mon_port_collision",
          (bus.ram_read_a | bus.ram_write_a) & (bus.ram_read_b | bus.ram_write_b) &
          (bus.ram_addr_a == bus.ram_addr_b) & (bus.ram_write_a | bus.ram_write_b), 0);
      chk("mon_port_a_idle", (!bus.ram_read_a && !bus.ram_write_a) ?
          {bus.ram_addr_a, bus.ram_wdata_a} : 12'h0, 0);
      chk("mon_port_b_idle", (!bus.ram_read_b && !bus.ram_write_b) ?
          {bus.ram_addr_b, bus.ram_wdata_b} : 12'h0, 0);

      m_cf  = bus.c0_req_valid && bus.c1_req_valid && (bus.c0_req_addr == bus.c1_req_addr) &&
              (bus.c0_req_we || bus.c1_req_we);
      m_er0 = !m_cf || !prio_m;
      m_er1 = !m_cf || prio_m;
      chk("mon_c0_ready", bus.c0_req_ready, m_er0);
      chk("mon_c1_ready", bus.c1_req_ready, m_er1);
      m_ea0 = bus.c0_req_valid && m_er0;
      m_ea1 = bus.c1_req_valid && m_er1;
      if (m_ea0 && !bus.c0_req_we) begin
        m_ent.due = cyc + 3; m_ent.data = shadow[bus.c0_req_addr]; q0.push_back(m_ent);
      end
      if (m_ea1 && !bus.c1_req_we) begin
        m_ent.due = cyc + 3; m_ent.data = shadow[bus.c1_req_addr]; q1.push_back(m_ent);
      end
      if (m_ea0 && bus.c0_req_we) shadow[bus.c0_req_addr] = bus.c0_req_wdata;
      if (m_ea1 && bus.c1_req_we) shadow[bus.c1_req_addr] = bus.c1_req_wdata;
`ifdef DPRAM_CTRL_RR_EN
      if (m_cf) prio_m = !prio_m;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit v, input bit we, input logic [3:0] a, input logic [7:0] d);
    bus.c0_req_valid = v; bus.c0_req_we = we; bus.c0_req_addr = a; bus.c0_req_wdata = d;
  endtask

  task automatic drive1(input bit v, input bit we, input logic [3:0] a, input logic [7:0] d);
    bus.c1_req_valid = v; bus.c1_req_we = we; bus.c1_req_addr = a; bus.c1_req_wdata = d;
  endtask

  task automatic idle_reqs();
    drive0(1'b0, 1'b0, 4'h0, 8'h00);
    drive1(1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic do_reset();
    idle_reqs();
    step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Call right after the accepting edge; response must appear exactly lat edges later.
  task automatic rsp_after(input bit cl, input int lat, input logic [7:0] exp, input string name);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) chk({name, "_early"}, cl ? bus.c1_rsp_valid : bus.c0_rsp_valid, 0);
      else begin
        chk({name, "_valid"}, cl ? bus.c1_rsp_valid : bus.c0_rsp_valid, 1);
        chk({name, "_rdata"}, cl ? bus.c1_rsp_rdata : bus.c0_rsp_rdata, exp);
      end
    end
  endtask

  typedef struct {
    bit         v0, we0;
    logic [3:0] a0;
    bit         v1, we1;
    logic [3:0] a1;
    bit         r0, r1;
    bit         r0_rr, r1_rr;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold0, hold1, exp1, er0, er1;

    //            v0 we0 a0    v1 we1 a1    r0 r1 r0rr r1rr
    tbl[0] = '{1, 0, 4'h3, 0, 0, 4'h0, 1, 1, 1, 1};
    tbl[1] = '{0, 0, 4'h0, 1, 1, 4'h4, 1, 1, 1, 1};
    tbl[2] = '{1, 0, 4'h7, 1, 0, 4'h7, 1, 1, 1, 1};
    tbl[3] = '{1, 1, 4'h1, 1, 1, 4'h2, 1, 1, 1, 1};
    tbl[4] = '{1, 1, 4'h5, 1, 1, 4'h5, 1, 0, 1, 0};
    tbl[5] = '{1, 0, 4'h6, 1, 1, 4'h6, 1, 0, 0, 1};
    tbl[6] = '{1, 1, 4'h8, 1, 0, 4'h8, 1, 0, 1, 0};
    tbl[7] = '{1, 1, 4'h9, 1, 0, 4'hA, 1, 1, 1, 1};
    tbl[8] = '{0, 0, 4'h0, 0, 0, 4'h0, 1, 1, 1, 1};

    idle_reqs();
    bus.ram_rdata_a = 8'h00;
    bus.ram_rdata_b = 8'h00;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      drive0(tbl[i].v0, tbl[i].we0, tbl[i].a0, 8'(8'h40 + i));
      drive1(tbl[i].v1, tbl[i].we1, tbl[i].a1, 8'(8'h80 + i));
      @(negedge clk);
`ifdef DPRAM_CTRL_RR_EN
      er0 = tbl[i].r0_rr; er1 = tbl[i].r1_rr;
`else
      er0 = tbl[i].r0;    er1 = tbl[i].r1;
`endif
      chk($sformatf("tbl%0d_c0_ready", i), bus.c0_req_ready, er0);
      chk($sformatf("tbl%0d_c1_ready", i), bus.c1_req_ready, er1);
      step();
    end
    idle_reqs();
    repeat (4) step();

    // Reset in the middle of a read, then write/read back
    do_reset();
    drive0(1'b1, 1'b0, 4'h3, 8'h00);
    step();
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_c0_ready", bus.c0_req_ready, 0);
    chk("rst_c1_ready", bus.c1_req_ready, 0);
    chk("rst_rsp", {bus.c0_rsp_valid, bus.c0_rsp_rdata, bus.c1_rsp_valid, bus.c1_rsp_rdata}, 0);
    chk("rst_ram_a", {bus.ram_read_a, bus.ram_write_a, bus.ram_addr_a, bus.ram_wdata_a}, 0);
    chk("rst_ram_b", {bus.ram_read_b, bus.ram_write_b, bus.ram_addr_b, bus.ram_wdata_b}, 0);
    step();
    idle_reqs();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", {bus.c0_rsp_valid, bus.c1_rsp_valid}, 0);
    end
    step();
    drive0(1'b1, 1'b1, 4'h3, 8'hA5);
    step();
    drive0(1'b1, 1'b0, 4'h3, 8'h00);
    step();
    idle_reqs();
    rsp_after(1'b0, 2, 8'hA5, "t1_read");

    // Write/write conflict: c1 stalls one cycle, its data lands last
    do_reset();
    drive0(1'b1, 1'b1, 4'h5, 8'h11);
    drive1(1'b1, 1'b1, 4'h5, 8'h22);
    @(negedge clk);
    chk("t2_c0_ready", bus.c0_req_ready, 1);
    chk("t2_c1_stalled", bus.c1_req_ready, 0);
    step();
    drive0(1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    chk("t2_c1_ready_next", bus.c1_req_ready, 1);
    step();
    idle_reqs();
    drive0(1'b1, 1'b0, 4'h5, 8'h00);
    step();
    idle_reqs();
    rsp_after(1'b0, 2, 8'h22, "t2_read");

    // Two reads of the same address are not a conflict
    do_reset();
    drive0(1'b1, 1'b1, 4'h7, 8'h6C);
    step();
    drive0(1'b1, 1'b0, 4'h7, 8'h00);
    drive1(1'b1, 1'b0, 4'h7, 8'h00);
    @(negedge clk);
    chk("t3_ready_both", {bus.c0_req_ready, bus.c1_req_ready}, 2'b11);
    step();
    idle_reqs();
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (k < 2) chk("t3_early", {bus.c0_rsp_valid, bus.c1_rsp_valid}, 2'b00);
      else begin
        chk("t3_valid_both", {bus.c0_rsp_valid, bus.c1_rsp_valid}, 2'b11);
        chk("t3_c0_rdata", bus.c0_rsp_rdata, 8'h6C);
        chk("t3_c1_rdata", bus.c1_rsp_rdata, 8'h6C);
      end
    end

    // Write and read to different addresses in one cycle use both ports
    do_reset();
    drive1(1'b1, 1'b1, 4'h9, 8'h9C);
    step();
    idle_reqs();
    drive0(1'b1, 1'b1, 4'h2, 8'h33);
    drive1(1'b1, 1'b0, 4'h9, 8'h00);
    @(negedge clk);
    chk("t4_ready_both", {bus.c0_req_ready, bus.c1_req_ready}, 2'b11);
    step();
    idle_reqs();
    @(negedge clk);
    chk("t4_port_a", {bus.ram_read_a, bus.ram_write_a, bus.ram_addr_a, bus.ram_wdata_a},
        {1'b0, 1'b1, 4'h2, 8'h33});
    chk("t4_port_b", {bus.ram_read_b, bus.ram_write_b, bus.ram_addr_b, bus.ram_wdata_b},
        {1'b1, 1'b0, 4'h9, 8'h00});
    rsp_after(1'b1, 1, 8'h9C, "t4_c1_read");

    // Continuous same-address writes from both clients
    do_reset();
    drive0(1'b1, 1'b1, 4'h1, 8'h10);
    drive1(1'b1, 1'b1, 4'h1, 8'h20);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef DPRAM_CTRL_RR_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      chk($sformatf("t5_c0_accept%0d", i), bus.c0_req_ready, !exp1);
      chk($sformatf("t5_c1_accept%0d", i), bus.c1_req_ready, exp1);
      step();
    end
    idle_reqs();

    // Read right after a write to the same address returns the new data
    do_reset();
    drive0(1'b1, 1'b1, 4'hF, 8'h5A);
    step();
    idle_reqs();
    drive1(1'b1, 1'b0, 4'hF, 8'h00);
    step();
    idle_reqs();
    rsp_after(1'b1, 2, 8'h5A, "t6_c1_read");

    // Random traffic on a narrow address range to provoke conflicts
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      hold0 = bus.c0_req_valid && !bus.c0_req_ready;
      hold1 = bus.c1_req_valid && !bus.c1_req_ready;
      step();
      if (!hold0) drive0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 3)), 8'($urandom));
      if (!hold1) drive1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 3)), 8'($urandom));
    end
    idle_reqs();
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
